// File: rtl/thresholds_axilite_loader.sv
// Purpose: reads K-bit threshold words from a stream and writes each one over AXI-lite to consecutive word addresses.
// Latency: 4 cycles per word with a zero-wait slave (fetch, issue, B wait, B accept); done rises the cycle after the last B.
// Backpressure: tready is high only in FETCH; AW/W are held stable until their handshakes; one write outstanding at a time.
module thresholds_axilite_loader #(
  parameter int K         = 8,
  parameter int SIGNED    = 1,
  parameter int COUNT     = 4,
  parameter int ADDR_BITS = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tvalid,
  input  logic [((K+7)/8)*8-1:0]   s_axis_tdata,
  output logic                     m_axilite_AWVALID,
  input  logic                     m_axilite_AWREADY,
  output logic [ADDR_BITS-1:0]     m_axilite_AWADDR,
  output logic [2:0]               m_axilite_AWPROT,
  output logic                     m_axilite_WVALID,
  input  logic                     m_axilite_WREADY,
  output logic [31:0]              m_axilite_WDATA,
  output logic [3:0]               m_axilite_WSTRB,
  input  logic                     m_axilite_BVALID,
  output logic                     m_axilite_BREADY,
  input  logic [1:0]               m_axilite_BRESP
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IW-1:0]        r_idx;
  logic                 r_done;
  logic                 r_err;
  logic                 r_tready;
  logic                 r_awvalid;
  logic                 r_wvalid;
  logic                 r_bready;
  logic [ADDR_BITS-1:0] r_awaddr;
  logic [31:0]          r_wdata;

  logic                 w_start_acc;
  logic                 w_s_fire;
  logic                 w_aw_done;
  logic                 w_w_done;
  logic                 w_b_fire;
  logic                 w_last;
  logic                 w_tready_nxt;
  logic                 w_awvalid_nxt;
  logic                 w_wvalid_nxt;
  logic                 w_bready_nxt;
  logic [31:0]          w_ext;
  logic [ADDR_BITS-1:0] w_addr;

  // Handshake decodes. A channel counts as done once its VALID has dropped
  // or its handshake is happening this cycle, so both orders and same-cycle work.
  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_s_fire    = r_tready && s_axis_tvalid;
  assign w_aw_done   = !r_awvalid || m_axilite_AWREADY;
  assign w_w_done    = !r_wvalid || m_axilite_WREADY;
  assign w_b_fire    = r_bready && m_axilite_BVALID;
  assign w_last      = (r_idx == IW'(COUNT - 1));
  assign w_addr      = ADDR_BITS'(BASE_ADDR) + ADDR_BITS'({r_idx, 2'b00});

  // Only the low K bits of the stream word carry the threshold.
  if (K < 32) begin : g_ext
    logic [31-K:0] w_fill;
    assign w_fill = (SIGNED != 0) ? {(32-K){s_axis_tdata[K-1]}} : '0;
    assign w_ext  = {w_fill, s_axis_tdata[K-1:0]};
  end else begin : g_full
    assign w_ext = s_axis_tdata[31:0];
  end

  // State register.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)                  w_state_nxt = S_FETCH;
      S_FETCH: if (w_s_fire)               w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_aw_done && w_w_done)  w_state_nxt = S_RESP;
      S_RESP:  if (w_b_fire)               w_state_nxt = w_last ? S_IDLE : S_FETCH;
      default:                             w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: busy straight from state, everything else prepared for its register.
  always_comb begin
    busy          = (r_state != S_IDLE);
    w_tready_nxt  = (w_state_nxt == S_FETCH);
    w_bready_nxt  = (w_state_nxt == S_RESP);
    w_awvalid_nxt = w_s_fire || (r_awvalid && !m_axilite_AWREADY);
    w_wvalid_nxt  = w_s_fire || (r_wvalid && !m_axilite_WREADY);
  end

  // Registered outputs, word index and sticky status flags.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_tready  <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_tready  <= w_tready_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
      r_bready  <= w_bready_nxt;
      if (w_s_fire) begin
        r_wdata  <= w_ext;
        r_awaddr <= w_addr;
      end
      if (w_start_acc) begin
        r_idx  <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_b_fire) begin
        if (m_axilite_BRESP != 2'b00) r_err <= 1'b1;
        if (w_last) r_done <= 1'b1;
        else        r_idx  <= r_idx + IW'(1);
      end
    end
  end

  assign done              = r_done;
  assign err               = r_err;
  assign s_axis_tready     = r_tready;
  assign m_axilite_AWVALID = r_awvalid;
  assign m_axilite_AWADDR  = r_awaddr;
  assign m_axilite_AWPROT  = 3'b000;
  assign m_axilite_WVALID  = r_wvalid;
  assign m_axilite_WDATA   = r_wdata;
  assign m_axilite_WSTRB   = 4'hF;
  assign m_axilite_BREADY  = r_bready;

endmodule

// File: tb/tb_thresholds_axilite_loader.sv
// Bench for thresholds_axilite_loader: a signed and an unsigned instance share one stream and one AXI-lite slave model.
// Stimulus pushes expected writes into a queue; the slave-side monitor pops and compares on each B handshake.
// Slave timing (AW/W ready delay, B latency, error response) is adjustable per load.
module tb_thresholds_axilite_loader;

  localparam int K     = 8;
  localparam int COUNT = 4;
  localparam int AB    = 8;
  localparam int BASE  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        awready;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;

  logic        s_busy, s_done, s_err, s_tready, s_awvalid, s_wvalid, s_bready;
  logic [7:0]  s_awaddr;
  logic [2:0]  s_awprot;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        u_busy, u_done, u_err, u_tready, u_awvalid, u_wvalid, u_bready;
  logic [7:0]  u_awaddr;
  logic [2:0]  u_awprot;
  logic [31:0] u_wdata;
  logic [3:0]  u_wstrb;

  always #5 clk = ~clk;

  thresholds_axilite_loader #(.K(K), .SIGNED(1), .COUNT(COUNT), .ADDR_BITS(AB), .BASE_ADDR(BASE)) u_dut_s (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start), .busy(s_busy), .done(s_done), .err(s_err),
    .s_axis_tready(s_tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axilite_AWVALID(s_awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(s_awaddr),
    .m_axilite_AWPROT(s_awprot), .m_axilite_WVALID(s_wvalid), .m_axilite_WREADY(wready),
    .m_axilite_WDATA(s_wdata), .m_axilite_WSTRB(s_wstrb), .m_axilite_BVALID(bvalid),
    .m_axilite_BREADY(s_bready), .m_axilite_BRESP(bresp)
  );

  thresholds_axilite_loader #(.K(K), .SIGNED(0), .COUNT(COUNT), .ADDR_BITS(AB), .BASE_ADDR(BASE)) u_dut_u (
    .ap_clk(clk), .ap_rst_n(rst_n), .start(start), .busy(u_busy), .done(u_done), .err(u_err),
    .s_axis_tready(u_tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .m_axilite_AWVALID(u_awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(u_awaddr),
    .m_axilite_AWPROT(u_awprot), .m_axilite_WVALID(u_wvalid), .m_axilite_WREADY(wready),
    .m_axilite_WDATA(u_wdata), .m_axilite_WSTRB(u_wstrb), .m_axilite_BVALID(bvalid),
    .m_axilite_BREADY(u_bready), .m_axilite_BRESP(bresp)
  );

  // Directed vectors: stream byte, expected signed WDATA, expected unsigned WDATA, expected AWADDR.
  logic [7:0]  tv_d [3][4] = '{'{8'h7F, 8'h80, 8'h01, 8'hFF},
                               '{8'h00, 8'h55, 8'hAA, 8'h81},
                               '{8'h3C, 8'hC3, 8'hFE, 8'h40}};
  logic [31:0] tv_s [3][4] = '{'{32'h0000007F, 32'hFFFFFF80, 32'h00000001, 32'hFFFFFFFF},
                               '{32'h00000000, 32'h00000055, 32'hFFFFFFAA, 32'hFFFFFF81},
                               '{32'h0000003C, 32'hFFFFFFC3, 32'hFFFFFFFE, 32'h00000040}};
  logic [31:0] tv_u [3][4] = '{'{32'h0000007F, 32'h00000080, 32'h00000001, 32'h000000FF},
                               '{32'h00000000, 32'h00000055, 32'h000000AA, 32'h00000081},
                               '{32'h0000003C, 32'h000000C3, 32'h000000FE, 32'h00000040}};
  logic [7:0]  tv_a [4]    = '{8'h10, 8'h14, 8'h18, 8'h1C};

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] s;
    logic [31:0] u;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] sq[$];

  int total = 0;
  int bad   = 0;

  // Slave model state
  bit          slv_hold = 1'b0;
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          b_lat    = 1;
  int          err_idx  = -1;
  int          wr_cnt   = 0;
  bit          aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, b_wait = 0;
  logic [7:0]  cap_addr;
  logic [31:0] cap_ds, cap_du;
  bit          prv_aw_pend = 1'b0, prv_aw_hs = 1'b0, prv_w_pend = 1'b0, prv_w_hs = 1'b0;
  logic [7:0]  prv_addr;
  logic [31:0] prv_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, req);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_busy"},    s_busy,    0);
    check({nm, "_done"},    s_done,    0);
    check({nm, "_err"},     s_err,     0);
    check({nm, "_tready"},  s_tready,  0);
    check({nm, "_awvalid"}, s_awvalid, 0);
    check({nm, "_wvalid"},  s_wvalid,  0);
    check({nm, "_bready"},  s_bready,  0);
    check({nm, "_awaddr"},  s_awaddr,  0);
    check({nm, "_wdata"},   s_wdata,   0);
    check({nm, "_awprot"},  s_awprot,  0);
    check({nm, "_wstrb"},   s_wstrb,   32'hF);
    check({nm, "_u_busy"},  u_busy,    0);
  endtask

  task automatic push_load(input int set);
    exp_t e;
    for (int i = 0; i < COUNT; i++) begin
      e.a = tv_a[i];
      e.s = tv_s[set][i];
      e.u = tv_u[set][i];
      exp_q.push_back(e);
      sq.push_back(tv_d[set][i]);
    end
  endtask

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic run_load(input string nm, input int mid, input int exp_busy);
    int cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_t1"},   s_busy,   1);
    check({nm, "_tready_t1"}, s_tready, 1);
    check({nm, "_done_clr"},  s_done,   0);
    check({nm, "_err_clr"},   s_err,    0);
    cnt = 0;
    while (s_busy && cnt < 300) begin
      start = (cnt == mid);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({nm, "_finished"}, s_busy, 0);
    if (exp_busy > 0) check({nm, "_busy_cycles"}, cnt, exp_busy);
    check({nm, "_done"},    s_done,       1);
    check({nm, "_u_done"},  u_done,       1);
    check({nm, "_pending"}, exp_q.size(), 0);
  endtask

  // Stream source, AXI-lite slave and write monitor. Inputs change on the falling
  // edge; a handshake seen here completes at the following rising edge.
  always @(negedge clk) begin
    if (!slv_hold && rst_n) begin
      tvalid = (sq.size() > 0);
      tdata  = tvalid ? sq[0] : 8'h00;
      if (tvalid && s_tready) sq.delete(0);

      if (prv_aw_pend) begin
        check("aw_held", s_awvalid, 1);
        check("aw_addr_stable", s_awaddr, prv_addr);
      end
      if (prv_aw_hs) check("aw_dropped", s_awvalid, 0);
      if (prv_w_pend) begin
        check("w_held", s_wvalid, 1);
        check("w_data_stable", s_wdata, prv_data);
      end
      if (prv_w_hs) check("w_dropped", s_wvalid, 0);

      bvalid = 1'b0;
      bresp  = 2'b00;
      if (b_pend) begin
        if (b_wait >= b_lat) begin
          bvalid = 1'b1;
          bresp  = (wr_cnt == err_idx) ? 2'b10 : 2'b00;
          check("bready", s_bready, 1);
          if (s_bready) begin
            check("wr_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              check("wr_addr",   cap_addr, exp_q[0].a);
              check("wr_data_s", cap_ds,   exp_q[0].s);
              check("wr_data_u", cap_du,   exp_q[0].u);
              exp_q.delete(0);
            end
            wr_cnt++;
            b_pend = 1'b0;
            aw_got = 1'b0;
            w_got  = 1'b0;
          end
        end else begin
          b_wait++;
        end
      end

      awready = 1'b0;
      if (s_awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) begin
          awready  = 1'b1;
          aw_got   = 1'b1;
          cap_addr = s_awaddr;
          aw_cnt   = 0;
        end else begin
          aw_cnt++;
        end
      end
      prv_aw_pend = s_awvalid && !awready;
      prv_aw_hs   = s_awvalid && awready;
      prv_addr    = s_awaddr;

      wready = 1'b0;
      if (s_wvalid && !w_got) begin
        if (w_cnt >= w_delay) begin
          wready = 1'b1;
          w_got  = 1'b1;
          cap_ds = s_wdata;
          cap_du = u_wdata;
          w_cnt  = 0;
          check("w_u_valid", u_wvalid, 1);
        end else begin
          w_cnt++;
        end
      end
      prv_w_pend = s_wvalid && !wready;
      prv_w_hs   = s_wvalid && wready;
      prv_data   = s_wdata;

      if (aw_got && w_got && !b_pend) begin
        b_pend = 1'b1;
        b_wait = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int base;
    int cnt;
    rst_n   = 1'b0;
    start   = 1'b0;
    tvalid  = 1'b0;
    tdata   = 8'h00;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    // Zero-wait slave: signed and unsigned extension of 7F,80,01,FF.
    push_load(0);
    run_load("basic", -1, 16);
    check("basic_err", s_err, 0);
    check("basic_writes", wr_cnt, 4);

    // AWREADY late by 3 cycles, then WREADY late by 3 cycles.
    aw_delay = 3;
    push_load(1);
    run_load("aw_late", -1, 28);
    aw_delay = 0;
    w_delay  = 3;
    push_load(2);
    run_load("w_late", -1, 28);
    w_delay = 0;
    check("late_writes", wr_cnt, 12);

    // Slave error on the second write: load still completes, err sticky.
    base    = wr_cnt;
    err_idx = base + 1;
    push_load(0);
    run_load("slverr", -1, 16);
    check("slverr_err", s_err, 1);
    check("slverr_u_err", u_err, 1);
    check("slverr_writes", wr_cnt - base, 4);
    err_idx = -1;
    push_load(1);
    run_load("clear", -1, 16);
    check("clear_err", s_err, 0);

    // Stream valid while idle must not be consumed; start during a load ignored.
    push_load(2);
    base = wr_cnt;
    repeat (8) @(negedge clk);
    check("idle_queue", sq.size(), 4);
    check("idle_tready", s_tready, 0);
    check("idle_writes", wr_cnt - base, 0);
    run_load("midstart", 6, 16);
    repeat (5) @(negedge clk);
    check("midstart_idle", s_busy, 0);
    check("midstart_done", s_done, 1);
    check("midstart_writes", wr_cnt - base, 4);

    // Reset while stalled in ISSUE, then a fresh load from the base address.
    aw_delay = 50;
    push_load(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!s_awvalid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("rst_reach_issue", s_awvalid, 1);
    @(posedge clk);
    #1;
    slv_hold = 1'b1;
    @(negedge clk);
    rst_n   = 1'b0;
    tvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    exp_q.delete();
    sq.delete();
    aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0;
    aw_cnt = 0; w_cnt = 0; b_wait = 0;
    prv_aw_pend = 1'b0; prv_aw_hs = 1'b0; prv_w_pend = 1'b0; prv_w_hs = 1'b0;
    aw_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset("midrst");
    slv_hold = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    push_load(0);
    run_load("fresh", -1, 16);
    check("fresh_writes", wr_cnt - base, 4);
    check("fresh_err", s_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
